// File: rtl/array_struct_type_read_arbiter_pkg.sv
// Shared types for the PULL-CU read arbiter: stream tags, FSM states, requester ids.
// Latency: none (types and a pure function only).
// Backpressure: n/a.
package array_struct_type_read_arbiter_pkg;

  typedef enum logic [1:0] {
    STRUCT_INVALID      = 2'd0,
    INV_EDGE_ARRAY_DEST = 2'd1,
    READ_GRAPH_DATA     = 2'd2
  } array_struct_type;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_type;

  localparam int ARB_REQ_EDGE  = 0;
  localparam int ARB_REQ_GRAPH = 1;

  // Requester index -> tag carried with the command so responses can be demuxed.
  function automatic array_struct_type req_to_sel(input logic idx);
    return (int'(idx) == ARB_REQ_EDGE) ? INV_EDGE_ARRAY_DEST : READ_GRAPH_DATA;
  endfunction

endpackage

// File: rtl/array_struct_type_read_arbiter_rr.sv
// Two-way round-robin arbiter: one-hot grant among eligible requesters.
// Latency: grant is combinational; pointer updates on the edge of an accepted grant.
// Backpressure: pointer holds unless accept_i is high, so a stalled grant is re-offered.
module round_robin_arbiter_2 (
  input  logic       clock,
  input  logic       rstn,
  input  logic       eligible [0:1],
  input  logic       accept_i,
  output logic [1:0] grant,
  output logic       grant_valid
);

  // ptr_q = index currently favoured (the one not granted last)
  logic ptr_q, ptr_d;

  // Pick the favoured requester if eligible, otherwise the other one.
  always_comb begin
    grant = 2'b00;
    if (ptr_q == 1'b0) begin
      if (eligible[0])      grant = 2'b01;
      else if (eligible[1]) grant = 2'b10;
    end else begin
      if (eligible[1])      grant = 2'b10;
      else if (eligible[0]) grant = 2'b01;
    end
    grant_valid = |grant;
    ptr_d = ptr_q;
    if (accept_i && grant_valid) ptr_d = grant[0];
  end

  // Pointer register; only an accepted grant moves it.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/array_struct_type_read_arbiter.sv
// Shares one tagged read-command channel between edge-dest and graph-data fetchers, with credits and drain.
// Latency: command appears registered one cycle after req_valid&req_ready; counters update on that edge.
// Backpressure: slot holds while cmd_out_ready=0; req_ready drops when slot busy, credits exhausted or draining.
// Optional stats outputs (issued_count, stall_cycles) under `ARRAY_STRUCT_ARB_STATS_EN.
module array_struct_type_read_arbiter
  import array_struct_type_read_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                  clock,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] req_addr      [0:1],
  input  logic                  req_valid     [0:1],
  output logic                  req_ready     [0:1],
  output logic [ADDR_WIDTH-1:0] cmd_out_addr,
  output array_struct_type      cmd_out_sel,
  output logic                  cmd_out_valid,
  input  logic                  cmd_out_ready,
  input  logic                  rsp_valid_in,
  input  array_struct_type      rsp_sel_in,
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic [CNT_WIDTH-1:0]  outstanding   [0:1],
  output logic                  rsp_underflow
`ifdef ARRAY_STRUCT_ARB_STATS_EN
  ,
  output logic [31:0]           issued_count  [0:1],
  output logic [31:0]           stall_cycles  [0:1]
`endif
);

  arb_state_type         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  array_struct_type      sel_q, sel_d;
  logic                  vld_q, vld_d;
  logic [CNT_WIDTH-1:0]  cnt_q [0:1];
  logic [CNT_WIDTH-1:0]  cnt_d [0:1];
  logic                  uf_q, uf_d;
  logic                  eligible [0:1];
  logic [1:0]            grant;
  logic                  grant_valid;
  logic                  slot_free;
  logic                  issue_en;
  logic                  accept;

  assign slot_free = !vld_q || cmd_out_ready;
  assign accept    = issue_en && grant_valid;

  round_robin_arbiter_2 u_rr (
    .clock       (clock),
    .rstn        (rstn),
    .eligible    (eligible),
    .accept_i    (accept),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // FSM next state; a rising drain_req blocks grants in the very cycle it is seen.
  always_comb begin
    state_d    = state_q;
    issue_en   = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      ARB_IDLE:  state_d = ARB_ISSUE;
      ARB_ISSUE: begin
        issue_en = slot_free && !drain_req;
        if (drain_req) state_d = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        drain_done = drain_req && !vld_q && (cnt_q[0] == '0) && (cnt_q[1] == '0);
        if (!drain_req) state_d = ARB_ISSUE;
      end
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Eligibility, per-requester ready, output slot load and credit counters.
  always_comb begin
    addr_d = addr_q;
    sel_d  = sel_q;
    vld_d  = vld_q;
    uf_d   = uf_q;
    for (int i = 0; i < 2; i++) begin
      eligible[i]  = req_valid[i] && (cnt_q[i] < CNT_WIDTH'(MAX_OUTSTANDING));
      req_ready[i] = issue_en && grant[i];
    end
    if (accept) begin
      addr_d = grant[1] ? req_addr[1] : req_addr[0];
      sel_d  = req_to_sel(grant[1]);
      vld_d  = 1'b1;
    end else if (cmd_out_ready) begin
      vld_d  = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      logic inc, dec;
      inc      = accept && grant[i];
      dec      = rsp_valid_in && (rsp_sel_in == req_to_sel(1'(i)));
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end else if (dec && !inc) begin
        if (cnt_q[i] == '0) uf_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
      end
    end
  end

  // State, output slot, counters and sticky underflow.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARB_IDLE;
      addr_q  <= '0;
      sel_q   <= STRUCT_INVALID;
      vld_q   <= 1'b0;
      cnt_q   <= '{default: '0};
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      uf_q    <= uf_d;
    end
  end

  assign cmd_out_addr  = addr_q;
  assign cmd_out_sel   = sel_q;
  assign cmd_out_valid = vld_q;
  assign outstanding   = cnt_q;
  assign rsp_underflow = uf_q;

`ifdef ARRAY_STRUCT_ARB_STATS_EN
  logic [31:0] issued_q [0:1];
  logic [31:0] stall_q  [0:1];

  // Free-running per-requester accept and stall counters, wrapping at 2^32.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      issued_q <= '{default: '0};
      stall_q  <= '{default: '0};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i])  issued_q[i] <= issued_q[i] + 32'd1;
        if (req_valid[i] && !req_ready[i]) stall_q[i]  <= stall_q[i] + 32'd1;
      end
    end
  end

  assign issued_count = issued_q;
  assign stall_cycles = stall_q;
`endif

endmodule
